rs_decoder: RTL and testbench
=============================

// Module: rs_decoder
// PURPOSE
// - Pipelined single-symbol-correcting Reed-Solomon RS(7,5) decoder over GF(2^3); one received word in per clock.
// - Computes syndromes, locates and corrects at most one erroneous symbol, and outputs the full corrected N-symbol codeword.
// - Sits after the channel/receive path; its output feeds the message extractor, which takes the top K symbols.
// PARAMETERS
// - SYMBOL_WIDTH  3  bits per symbol (GF(2^3), primitive poly x^3+x+1, alpha = 3'b010)
// - N             7  codeword length in symbols
// - K             5  message length in symbols; T=(N-K)/2=1 correctable symbol
// - Only the defaults are supported; any other value must trigger an elaboration-time $error.
// PORTS
// - clk            input   1                  clock, rising-edge active
// - reset          input   1                  asynchronous, active-low reset
// - in_valid       input   1                  codeword is valid this cycle
// - codeword       input   N*SYMBOL_WIDTH     received word; [20:18] = coeff of x^6 ... [2:0] = coeff of x^0
// - out_valid      output  1                  corrected is valid this cycle
// - corrected      output  N*SYMBOL_WIDTH     corrected word, same packing as codeword
// BEHAVIOUR
// - Code: systematic; generator g(x)=(x+a)(x+a^2)=x^2+6x+3; top K symbols = message, low 2 = parity.
// - Stage 1 (posedge): register codeword, in_valid, S1=r(a), S2=r(a^2) (sum of c_i*a^(i*j), GF add = XOR).
// - Stage 2 (posedge): register corrected and out_valid; latency exactly 2 clocks, throughput 1 word/clock, no stall.
// - S1==0 && S2==0: no error; corrected = codeword.
// - S1!=0 && S2!=0: single error; X=S2/S1=a^p gives position p (0..6), magnitude e=S1^2/S2; XOR e into symbol p.
// - Exactly one of S1,S2 zero: uncorrectable; corrected = codeword unmodified.
// - 2+ symbol errors with both syndromes nonzero miscorrect silently; no detection required.
// - GF multiply/inverse via combinational log/antilog tables or explicit polynomial reduction; no multicycle paths.
// - Pipeline registers load on every posedge irrespective of in_valid; out_valid simply follows in_valid by 2 clocks.
// - Reset assertion (reset=0), any time incl. mid-stream: immediately clear all stage registers; corrected=0, out_valid=0,
//   status outputs=0. Data in flight is discarded; first valid output appears 2 edges after the first post-reset sample.
// CONFIGURATION
// - RS_DEC_STATUS_EN defined: extra registered outputs aligned with corrected (same 2-clock latency, reset to 0):
//     err_detected  output 1  any syndrome nonzero
//     uncorrectable output 1  exactly one syndrome zero
//     err_pos       output 3  corrected symbol index p (0 when no correction)
// - RS_DEC_STATUS_EN undefined: those ports and their logic are absent; data path behaviour is identical.
// TESTING
// - All-zero codeword, in_valid=1 -> after 2 clocks corrected=21'h000000, out_valid=1, err_detected=0.
// - Valid word g(x)=21'h000073 -> corrected=21'h000073; error at x^1 (in 21'h000043, S1=7,S2=5) -> corrected 21'h000073, err_pos=1.
// - Error 3'b001 at x^6 (in 21'h040000; S1=5,S2=7) -> corrected 21'h000000, err_pos=6.
// - Two errors giving S1=0,S2=6 (in 21'h00000A) -> corrected 21'h00000A unchanged, uncorrectable=1.
// - Back-to-back stream of 3 words, one per clock -> 3 consecutive out_valid cycles, results in order, 2-clock latency.
// - Drop reset mid-stream with word in flight -> corrected=0,out_valid=0 at once; release; next word out 2 clocks later.

Source files
------------

// File: rtl/rs_decoder.sv
// rtl/rs_decoder.sv - two-stage RS(7,5) single-symbol-correcting decoder over GF(2^3).
// Optional registered status outputs (err_detected, uncorrectable, err_pos) under RS_DEC_STATUS_EN.
module rs_decoder #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int K            = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [N*SYMBOL_WIDTH-1:0] codeword,
  output logic                      out_valid,
`ifdef RS_DEC_STATUS_EN
  output logic                      err_detected,
  output logic                      uncorrectable,
  output logic [2:0]                err_pos,
`endif
  output logic [N*SYMBOL_WIDTH-1:0] corrected
);

  localparam int SW = SYMBOL_WIDTH;
  localparam int W  = N * SYMBOL_WIDTH;

  generate
    if (SYMBOL_WIDTH != 3 || N != 7 || K != 5) begin : g_bad_params
      $error("rs_decoder supports only SYMBOL_WIDTH=3, N=7, K=5");
    end
  endgenerate

  // Antilog of an exponent taken mod 7 (alpha = x, poly x^3+x+1).
  function automatic logic [2:0] gf_alog(input int e);
    int m;
    m = e % 7;
    case (m)
      0:       gf_alog = 3'd1;
      1:       gf_alog = 3'd2;
      2:       gf_alog = 3'd4;
      3:       gf_alog = 3'd3;
      4:       gf_alog = 3'd6;
      5:       gf_alog = 3'd7;
      default: gf_alog = 3'd5;
    endcase
  endfunction

  function automatic int gf_log(input logic [2:0] v);
    case (v)
      3'd1:    gf_log = 0;
      3'd2:    gf_log = 1;
      3'd4:    gf_log = 2;
      3'd3:    gf_log = 3;
      3'd6:    gf_log = 4;
      3'd7:    gf_log = 5;
      3'd5:    gf_log = 6;
      default: gf_log = 0;
    endcase
  endfunction

  logic [SW-1:0] s1_c, s2_c, s1_q, s2_q;
  logic [W-1:0]  word_q;
  logic          valid_q;

  always_comb begin
    logic [2:0] sym;
    sym  = '0;
    s1_c = '0;
    s2_c = '0;
    for (int i = 0; i < N; i++) begin
      sym = codeword[i*SW +: SW];
      if (sym != 3'd0) begin
        s1_c = s1_c ^ gf_alog(gf_log(sym) + i);
        s2_c = s2_c ^ gf_alog(gf_log(sym) + 2 * i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      word_q  <= codeword;
      valid_q <= in_valid;
      s1_q    <= s1_c;
      s2_q    <= s2_c;
    end
  end

  // Locator X = S2/S1 = a^p, magnitude e = S1^2/S2, both done in the log domain.
  logic          fix_c;
  logic [2:0]    pos_c;
  logic [SW-1:0] mag_c;
  logic [W-1:0]  corr_c;

  always_comb begin
    int ls1, ls2, pos_int;
    ls1     = gf_log(s1_q);
    ls2     = gf_log(s2_q);
    pos_int = (ls2 - ls1 + 7) % 7;
    pos_c   = pos_int[2:0];
    mag_c   = gf_alog(2 * ls1 - ls2 + 7);
    fix_c   = (s1_q != '0) && (s2_q != '0);
    corr_c  = word_q;
    for (int i = 0; i < N; i++) begin
      if (fix_c && (pos_c == i[2:0])) begin
        corr_c[i*SW +: SW] = word_q[i*SW +: SW] ^ mag_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corrected <= '0;
      out_valid <= 1'b0;
    end else begin
      corrected <= corr_c;
      out_valid <= valid_q;
    end
  end

`ifdef RS_DEC_STATUS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_detected  <= 1'b0;
      uncorrectable <= 1'b0;
      err_pos       <= 3'd0;
    end else begin
      err_detected  <= (s1_q != '0) || (s2_q != '0);
      uncorrectable <= (s1_q == '0) != (s2_q == '0);
      err_pos       <= fix_c ? pos_c : 3'd0;
    end
  end
`endif

endmodule

// File: tb/tb_rs_decoder.sv
// tb/tb_rs_decoder.sv - directed-vector self-checking bench for rs_decoder.
module tb_rs_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [20:0] codeword;
  logic        out_valid;
  logic [20:0] corrected;
`ifdef RS_DEC_STATUS_EN
  logic        err_detected;
  logic        uncorrectable;
  logic [2:0]  err_pos;
`endif

  int tests_run;
  int tests_failed;

  rs_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .codeword     (codeword),
    .out_valid    (out_valid),
`ifdef RS_DEC_STATUS_EN
    .err_detected (err_detected),
    .uncorrectable(uncorrectable),
    .err_pos      (err_pos),
`endif
    .corrected    (corrected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic det, input logic unc, input logic [2:0] pos);
`ifdef RS_DEC_STATUS_EN
    check({tag, ".err_detected"}, 32'(err_detected), 32'(det));
    check({tag, ".uncorrectable"}, 32'(uncorrectable), 32'(unc));
    check({tag, ".err_pos"}, 32'(err_pos), 32'(pos));
`endif
  endtask

  // Single word: present at a negedge, result visible at the negedge two edges later.
  task automatic run_one(input string tag, input logic [20:0] w, input logic [20:0] exp,
                         input logic det, input logic unc, input logic [2:0] pos);
    @(negedge clk);
    in_valid = 1'b1;
    codeword = w;
    @(negedge clk);
    in_valid = 1'b0;
    codeword = '0;
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".corrected"}, 32'(corrected), 32'(exp));
    check_status(tag, det, unc, pos);
  endtask

  logic [20:0] stream_in  [3];
  logic [20:0] stream_exp [3];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = 1'b0;
    codeword     = '0;
    reset        = 1'b0;
    #12;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.corrected", 32'(corrected), 32'd0);
    check_status("reset", 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    reset = 1'b1;

    run_one("zero",       21'h000000, 21'h000000, 1'b0, 1'b0, 3'd0);
    run_one("valid_g",    21'h000073, 21'h000073, 1'b0, 1'b0, 3'd0);
    run_one("err_x1",     21'h000043, 21'h000073, 1'b1, 1'b0, 3'd1);
    run_one("err_x6",     21'h040000, 21'h000000, 1'b1, 1'b0, 3'd6);
    run_one("two_err",    21'h00000A, 21'h00000A, 1'b1, 1'b1, 3'd0);
    run_one("err_x0",     21'h000074, 21'h000073, 1'b1, 1'b0, 3'd0);
    run_one("err_x4",     21'h005398, 21'h000398, 1'b1, 1'b0, 3'd4);
    run_one("valid_xg",   21'h000398, 21'h000398, 1'b0, 1'b0, 3'd0);

    stream_in[0] = 21'h000043; stream_exp[0] = 21'h000073;
    stream_in[1] = 21'h040000; stream_exp[1] = 21'h000000;
    stream_in[2] = 21'h005398; stream_exp[2] = 21'h000398;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        check($sformatf("stream%0d.out_valid", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("stream%0d.corrected", c - 2), 32'(corrected), 32'(stream_exp[c-2]));
      end
      if (c == 5) check("stream.tail_valid", 32'(out_valid), 32'd0);
      in_valid = (c < 3);
      codeword = (c < 3) ? stream_in[c] : 21'h0;
    end

    // Two words in flight, then reset mid-cycle.
    @(negedge clk);
    in_valid = 1'b1;
    codeword = 21'h000073;
    @(negedge clk);
    codeword = 21'h000043;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset.out_valid", 32'(out_valid), 32'd0);
    check("midreset.corrected", 32'(corrected), 32'd0);
    check_status("midreset", 1'b0, 1'b0, 3'd0);
    in_valid = 1'b0;
    codeword = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postreset.idle_valid", 32'(out_valid), 32'd0);
    run_one("postreset", 21'h040000, 21'h000000, 1'b1, 1'b0, 3'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
